// File: rtl/ps2_keys_pkg.sv
// Shared constants for the PS/2 keyboard front end: set-2 scancodes, framer states,
// output bit positions and the scancode-to-key lookup used by the decoder.
package ps2_keys_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_S     = 8'h1B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;
    localparam int KEY_START = 4;
    localparam int NUM_KEYS  = 5;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    // Valid frame: stop bit high and odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

    // Arrow keys only count with the E0 prefix; S only without it.
    function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r.hit = 1'b0;
        r.idx = 3'd0;
        if (ext) begin
            case (code)
                SC_UP:    begin r.hit = 1'b1; r.idx = 3'(DIR_UP);    end
                SC_DOWN:  begin r.hit = 1'b1; r.idx = 3'(DIR_DOWN);  end
                SC_LEFT:  begin r.hit = 1'b1; r.idx = 3'(DIR_LEFT);  end
                SC_RIGHT: begin r.hit = 1'b1; r.idx = 3'(DIR_RIGHT); end
                default:  r.hit = 1'b0;
            endcase
        end else if (code == SC_S) begin
            r.hit = 1'b1;
            r.idx = 3'(KEY_START);
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: pin synchronizers, clock glitch filter, 11-bit framer
// and inter-edge timeout. Emits one-cycle byte_valid / frame_error pulses.
module ps2_rx_frame
    import ps2_keys_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    assign pin_raw = {ps2_dat, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    logic clk_s;
    logic dat_s;
    assign clk_s = pin_sync[0];
    assign dat_s = pin_sync[1];

    // The filtered level only follows clk_s after FILTER_CYCLES consecutive differing samples.
    logic          filt_reg;
    logic          filt_prev_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          fall_edge;

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_reg      <= 1'b1;
            filt_prev_reg <= 1'b1;
            filt_cnt_reg  <= '0;
        end else begin
            filt_prev_reg <= filt_reg;
            if (clk_s == filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_CYCLES - 1)) begin
                filt_reg     <= clk_s;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    assign fall_edge = filt_prev_reg & ~filt_reg;

    frame_state_t  state_reg, state_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic          parity_reg, parity_next;
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic          byte_valid_reg, byte_valid_next;
    logic          frame_error_reg, frame_error_next;
    logic          timeout;

    assign timeout = (state_reg != IDLE) && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            parity_reg      <= 1'b0;
            tmo_cnt_reg     <= '0;
            byte_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            parity_reg      <= parity_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            byte_valid_reg  <= byte_valid_next;
            frame_error_reg <= frame_error_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        parity_next  = parity_reg;
        tmo_cnt_next = (state_reg == IDLE || fall_edge) ? '0 : tmo_cnt_reg + 1'b1;
        if (timeout) begin
            state_next   = IDLE;
            shift_next   = '0;
            bit_cnt_next = '0;
            tmo_cnt_next = '0;
        end else if (fall_edge) begin
            case (state_reg)
                IDLE: begin
                    if (!dat_s) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {dat_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = dat_s;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_valid_next  = 1'b0;
        frame_error_next = 1'b0;
        if (timeout) begin
            frame_error_next = 1'b1;
        end else if (fall_edge && state_reg == STOP) begin
            if (frame_ok(shift_reg, parity_reg, dat_s)) begin
                byte_valid_next = 1'b1;
            end else begin
                frame_error_next = 1'b1;
            end
        end
    end

    assign byte_valid  = byte_valid_reg;
    assign byte_data   = shift_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard front end for 2048: turns set-2 scancodes into one-cycle direction/start pulses.
// Define PS2_TYPEMATIC_EN to let typematic repeats of a held key pulse again.
module ps2_direction_decoder
    import ps2_keys_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [3:0] direction,
    output logic       start_key,
    output logic       frame_error
);

`ifdef PS2_TYPEMATIC_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    logic       byte_valid;
    logic [7:0] byte_data;

    ps2_rx_frame #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_error(frame_error)
    );

    logic                e0_seen_reg, e0_seen_next;
    logic                f0_seen_reg, f0_seen_next;
    logic [NUM_KEYS-1:0] held_reg, held_next;
    logic [NUM_KEYS-1:0] pulse_reg, pulse_next;
    key_hit_t            hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            e0_seen_reg <= 1'b0;
            f0_seen_reg <= 1'b0;
            held_reg    <= '0;
            pulse_reg   <= '0;
        end else begin
            e0_seen_reg <= e0_seen_next;
            f0_seen_reg <= f0_seen_next;
            held_reg    <= held_next;
            pulse_reg   <= pulse_next;
        end
    end

    // Prefix bytes only set flags; any other byte consumes and clears them.
    always_comb begin
        e0_seen_next = e0_seen_reg;
        f0_seen_next = f0_seen_reg;
        held_next    = held_reg;
        pulse_next   = '0;
        hit          = key_lookup(byte_data, e0_seen_reg);
        if (byte_valid) begin
            if (byte_data == SC_E0) begin
                e0_seen_next = 1'b1;
            end else if (byte_data == SC_F0) begin
                f0_seen_next = 1'b1;
            end else begin
                if (hit.hit) begin
                    if (f0_seen_reg) begin
                        held_next[hit.idx] = 1'b0;
                    end else begin
                        if (!held_reg[hit.idx] || REPEAT_EN) begin
                            pulse_next[hit.idx] = 1'b1;
                        end
                        held_next[hit.idx] = 1'b1;
                    end
                end
                e0_seen_next = 1'b0;
                f0_seen_next = 1'b0;
            end
        end
    end

    assign direction = pulse_reg[DIR_UP:DIR_RIGHT];
    assign start_key = pulse_reg[KEY_START];

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: table of single frames plus hand sequences
// for timeout, glitch filtering and mid-frame reset.
module tb_ps2_direction_decoder;

    localparam int HALF    = 20;
    localparam int LATENCY = 12;

`ifdef PS2_TYPEMATIC_EN
    localparam logic [3:0] REP_LEFT = 4'b0010;
`else
    localparam logic [3:0] REP_LEFT = 4'b0000;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [3:0] direction;
    logic       start_key;
    logic       frame_error;

    always #5 clock = ~clock;

    ps2_direction_decoder #(
        .FILTER_CYCLES (8),
        .TIMEOUT_CYCLES(10000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .direction  (direction),
        .start_key  (start_key),
        .frame_error(frame_error)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         tot_dir = 0;
    int         tot_start = 0;
    int         tot_err = 0;
    int         last_pulse_cyc = 0;
    int         bad_shape = 0;
    logic [3:0] last_dir = 4'b0000;

    always @(negedge clock) begin
        if (direction != 4'b0000) begin
            tot_dir        <= tot_dir + 1;
            last_dir       <= direction;
            last_pulse_cyc <= cyc;
        end
        if (start_key) begin
            tot_start      <= tot_start + 1;
            last_pulse_cyc <= cyc;
        end
        if (frame_error) tot_err <= tot_err + 1;
        if (((direction & (direction - 4'd1)) != 4'b0000) || (direction != 4'b0000 && start_key))
            bad_shape <= bad_shape + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, output int stop_cyc);
        stop_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code);
        int sc;
        send_bits(frame_bits(code, 1'b0), 11, sc);
        wait_cyc(40);
    endtask

    typedef struct {
        logic [7:0] code;
        logic       bad;
        logic [3:0] dir;
        logic       start;
        logic       err;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    initial begin
        int d0, s0, e0, sc;

        vecs[0]  = '{8'hE0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{8'h75, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[2]  = '{8'h1B, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[3]  = '{8'hF0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{8'h1B, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{8'h1B, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[6]  = '{8'hE0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{8'h6B, 1'b0, 4'b0010, 1'b0, 1'b0};
        vecs[8]  = '{8'hE0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{8'h6B, 1'b0, REP_LEFT, 1'b0, 1'b0};
        vecs[10] = '{8'hE0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[11] = '{8'h6B, 1'b0, REP_LEFT, 1'b0, 1'b0};
        vecs[12] = '{8'h74, 1'b1, 4'b0000, 1'b0, 1'b1};
        vecs[13] = '{8'hE0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{8'h74, 1'b0, 4'b0001, 1'b0, 1'b0};
        vecs[15] = '{8'h75, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[16] = '{8'hE0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[17] = '{8'h72, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[18] = '{8'h1C, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[19] = '{8'hF0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[20] = '{8'h1B, 1'b0, 4'b0000, 1'b0, 1'b0};

        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(5);
        check("reset_direction", int'(direction), 0);
        check("reset_start_key", int'(start_key), 0);
        check("reset_frame_error", int'(frame_error), 0);
        reset = 1'b0;
        wait_cyc(20);

        for (int i = 0; i < NV; i++) begin
            d0 = tot_dir; s0 = tot_start; e0 = tot_err;
            send_bits(frame_bits(vecs[i].code, vecs[i].bad), 11, sc);
            wait_cyc(40);
            $display("[TB] vec %0d code=%02h bad=%0d dir_pulses=%0d dir=%b start_pulses=%0d errs=%0d",
                     i, vecs[i].code, vecs[i].bad, tot_dir - d0, last_dir, tot_start - s0, tot_err - e0);
            check($sformatf("v%0d_dir_count", i), tot_dir - d0, int'(vecs[i].dir != 4'b0000));
            if (vecs[i].dir != 4'b0000) check($sformatf("v%0d_dir_value", i), int'(last_dir), int'(vecs[i].dir));
            check($sformatf("v%0d_start_count", i), tot_start - s0, int'(vecs[i].start));
            check($sformatf("v%0d_err_count", i), tot_err - e0, int'(vecs[i].err));
            if (vecs[i].dir != 4'b0000 || vecs[i].start)
                check($sformatf("v%0d_latency", i), last_pulse_cyc - sc, LATENCY);
        end

        // Timeout: start bit plus 4 data bits, then the clock stops.
        d0 = tot_dir; s0 = tot_start; e0 = tot_err;
        send_bits(frame_bits(8'h1B, 1'b0), 5, sc);
        wait_cyc(10200);
        $display("[TB] timeout: errs=%0d dir_pulses=%0d start_pulses=%0d", tot_err - e0, tot_dir - d0, tot_start - s0);
        check("timeout_err_count", tot_err - e0, 1);
        check("timeout_no_pulse", (tot_dir - d0) + (tot_start - s0), 0);
        e0 = tot_err; s0 = tot_start;
        send_frame(8'h1B);
        $display("[TB] after timeout 1B: start_pulses=%0d errs=%0d", tot_start - s0, tot_err - e0);
        check("post_timeout_start", tot_start - s0, 1);
        check("post_timeout_no_err", tot_err - e0, 0);

        s0 = tot_start;
        send_frame(8'hF0);
        send_frame(8'h1B);
        $display("[TB] release S: start_pulses=%0d", tot_start - s0);
        check("release_s_no_pulse", tot_start - s0, 0);

        // Short ps2_clk glitches with data low must not be taken as a start bit.
        d0 = tot_dir; s0 = tot_start; e0 = tot_err;
        ps2_dat = 1'b0;
        for (int g = 0; g < 5; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(5);
        end
        ps2_dat = 1'b1;
        wait_cyc(20);
        send_frame(8'h1B);
        $display("[TB] glitch then 1B: start_pulses=%0d errs=%0d", tot_start - s0, tot_err - e0);
        check("glitch_start", tot_start - s0, 1);
        check("glitch_no_err", tot_err - e0, 0);

        // Reset mid-frame while up is still held from the table.
        d0 = tot_dir; e0 = tot_err;
        send_bits(frame_bits(8'h1B, 1'b0), 6, sc);
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(3);
        check("midreset_direction", int'(direction), 0);
        check("midreset_start_key", int'(start_key), 0);
        check("midreset_frame_error", int'(frame_error), 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(10500);
        $display("[TB] mid-frame reset: errs=%0d", tot_err - e0);
        check("midreset_no_err", tot_err - e0, 0);
        send_frame(8'hE0);
        send_frame(8'h75);
        $display("[TB] after reset E0 75: dir_pulses=%0d dir=%b", tot_dir - d0, last_dir);
        check("post_reset_up_count", tot_dir - d0, 1);
        check("post_reset_up_value", int'(last_dir), 8);

        wait_cyc(2);
        check("onehot_shape", bad_shape, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
